rx_data_ctrl: RTL and testbench
===============================

RX_DATA_CTRL -- requirements
Module: rx_data_ctrl

Interface
REQ-001 Parameter CNT_W, default 11, sets the byte-counter and length width.
REQ-002 Parameter TIMEOUT, default 16'd1000, sets the idle cycles allowed in ARMED/DATA before abort.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_arm  input  1  pulse from link_control: a DATA packet is expected.
REQ-006 rx_abort  input  1  synchronous abort from link_control.
REQ-007 rx_max_len  input  CNT_W  maximum permitted beats per packet, including SOP and EOP beats; sampled while IDLE.
REQ-008 rx_sop_en  input  1  pulse from the CRC16 receive stage marking the DATA SOP handshake.
REQ-009 rx_lt_eop_en  input  1  pulse from the CRC16 receive stage marking the DATA EOP handshake on the transfer side.
REQ-010 rx_lt_valid  input  1  transfer-side valid.
REQ-011 rx_lt_ready  input  1  transfer-side ready.
REQ-012 rx_data_on  output  1  enables the CRC16 receive stage.
REQ-013 rx_busy  output  1  high in every state except IDLE.
REQ-014 rx_len  output  CNT_W  beat count of the last completed or current packet.
REQ-015 rx_done  output  1  one-cycle pulse: packet completed within length.
REQ-016 rx_err_len  output  1  one-cycle pulse: length violation.
REQ-017 rx_timeout  output  1  one-cycle pulse: timeout abort.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, DATA and DONE, state-encoded and registered.
REQ-019 IDLE SHALL go to ARMED on rx_arm and latch rx_max_len into an internal limit register; rx_arm outside IDLE SHALL be ignored.
REQ-020 ARMED SHALL go to DATA on rx_sop_en and clear the beat counter to 0 in that cycle.
REQ-021 In DATA, each cycle with rx_lt_valid && rx_lt_ready SHALL increment the beat counter, saturating at 2^CNT_W-1.
REQ-022 In DATA, rx_lt_eop_en SHALL go to DONE; the beat in that cycle SHALL be counted before the length check.
REQ-023 In DATA, an updated count greater than the limit SHALL pulse rx_err_len and go to IDLE, taking precedence over a simultaneous rx_lt_eop_en.
REQ-024 DONE SHALL last exactly one cycle, assert rx_done, then return to IDLE.
REQ-025 rx_data_on SHALL be a registered output, high exactly while in ARMED or DATA, so it rises one cycle after rx_arm.
REQ-026 rx_abort SHALL force IDLE from any state on the next edge with no status pulse, overriding every other event in the same cycle.
REQ-027 rx_len SHALL track the counter while in DATA and hold its value in IDLE until the next rx_sop_en.
REQ-028 rx_done, rx_err_len and rx_timeout SHALL be registered and mutually exclusive.

Reset
REQ-029 Asserting rst SHALL immediately force state IDLE, all counters to 0, and all outputs to 0 (rx_len = 0), including mid-packet.
REQ-030 The first rx_arm after rst deassertion SHALL be honoured on the first clock edge.

Configuration
REQ-031 With macro RX_DATA_TIMEOUT_EN defined, an idle counter SHALL count cycles in ARMED/DATA with no rx_sop_en and no rx_lt_valid && rx_lt_ready, and clear on any such event or on state entry.
REQ-032 With RX_DATA_TIMEOUT_EN defined, the idle counter reaching TIMEOUT SHALL pulse rx_timeout and go to IDLE; rx_abort or a completing event in the same cycle SHALL take precedence.
REQ-033 With RX_DATA_TIMEOUT_EN undefined, no idle counter SHALL be built, rx_timeout SHALL be tied to 0, and ARMED/DATA SHALL wait indefinitely.

Verification
REQ-034 Normal packet: rx_max_len=8, arm, SOP, 6 beats with EOP on the 6th -> rx_data_on high from arm+1, rx_done pulse, rx_len=6, no error.
REQ-035 Over-length: rx_max_len=4, 5 beats, no EOP by beat 5 -> rx_err_len on beat 5, IDLE, rx_data_on low next cycle.
REQ-036 Boundary: rx_max_len=4, EOP exactly on beat 4 -> rx_done; rx_max_len=3 with EOP on beat 4 -> rx_err_len only.
REQ-037 Abort and reset: rx_abort in DATA after 2 beats -> IDLE, no pulses, rx_len=2; rst mid-packet -> all outputs 0 immediately.
REQ-038 Timeout (macro on, TIMEOUT=10): arm, no SOP for 10 cycles -> rx_timeout pulse, IDLE; macro off -> remains ARMED after 100 cycles.

Source files
------------

// File: rtl/rx_data_ctrl.sv
// rx_data_ctrl: DATA packet receive sequencer with length check; idle timeout is built only with RX_DATA_TIMEOUT_EN
module rx_data_ctrl #(
    parameter int          CNT_W   = 11,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_arm,
    input  logic             rx_abort,
    input  logic [CNT_W-1:0] rx_max_len,
    input  logic             rx_sop_en,
    input  logic             rx_lt_eop_en,
    input  logic             rx_lt_valid,
    input  logic             rx_lt_ready,
    output logic             rx_data_on,
    output logic             rx_busy,
    output logic [CNT_W-1:0] rx_len,
    output logic             rx_done,
    output logic             rx_err_len,
    output logic             rx_timeout
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, DATA = 2'd2, DONE = 2'd3;
    logic [1:0] state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d, cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic data_on_q, data_on_d, done_q, done_d, err_q, err_d, to_q, to_d;
    logic beat, over, tmo;
    assign beat    = rx_lt_valid && rx_lt_ready;
    assign cnt_inc = (beat && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    assign over    = cnt_inc > limit_q;
`ifdef RX_DATA_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic waiting;
    assign waiting = (state_q == ARMED || state_q == DATA) && !rx_sop_en && !beat;
    assign tmo     = waiting && (idle_q + 16'd1 == TIMEOUT);
    assign idle_d  = (waiting && state_d == state_q) ? idle_q + 16'd1 : 16'd0;
    always_ff @(posedge clk or posedge rst)
        if (rst) idle_q <= 16'd0;
        else     idle_q <= idle_d;
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        if (rx_abort) state_d = IDLE;
        else case (state_q)
            IDLE: if (rx_arm) begin
                state_d = ARMED;
                limit_d = rx_max_len;
            end
            ARMED: if (rx_sop_en) begin
                state_d = DATA;
                cnt_d   = '0;
                len_d   = '0;
            end else if (tmo) begin
                state_d = IDLE;
                to_d    = 1'b1;
            end
            DATA: begin
                cnt_d = cnt_inc;
                len_d = cnt_inc;
                if (over) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (rx_lt_eop_en) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (tmo) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        data_on_d = state_d == ARMED || state_d == DATA;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            data_on_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            data_on_q <= data_on_d;
            done_q    <= done_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    assign rx_data_on = data_on_q;
    assign rx_busy    = state_q != IDLE;
    assign rx_len     = len_q;
    assign rx_done    = done_q;
    assign rx_err_len = err_q;
    assign rx_timeout = to_q;
endmodule

// File: tb/tb_rx_data_ctrl.sv
// tb_rx_data_ctrl: table-driven per-cycle checks plus reset and timeout sequences
module tb_rx_data_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic rx_arm = 1'b0, rx_abort = 1'b0, rx_sop_en = 1'b0, rx_lt_eop_en = 1'b0;
    logic rx_lt_valid = 1'b0, rx_lt_ready = 1'b0;
    logic [10:0] rx_max_len = '0;
    logic rx_data_on, rx_busy, rx_done, rx_err_len, rx_timeout;
    logic [10:0] rx_len;
    int pass_cnt = 0, total = 0;
    typedef struct packed {
        logic arm, abort;
        logic [10:0] ml;
        logic sop, eop;
        logic [1:0] vr;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];
    rx_data_ctrl #(.CNT_W(11), .TIMEOUT(16'd10)) dut (
        .clk(clk), .rst(rst), .rx_arm(rx_arm), .rx_abort(rx_abort), .rx_max_len(rx_max_len),
        .rx_sop_en(rx_sop_en), .rx_lt_eop_en(rx_lt_eop_en), .rx_lt_valid(rx_lt_valid),
        .rx_lt_ready(rx_lt_ready), .rx_data_on(rx_data_on), .rx_busy(rx_busy), .rx_len(rx_len),
        .rx_done(rx_done), .rx_err_len(rx_err_len), .rx_timeout(rx_timeout)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] outs();
        return {rx_data_on, rx_busy, rx_len, rx_done, rx_err_len, rx_timeout};
    endfunction
    task automatic check(input string name, input logic [15:0] exp);
        total++;
        if (outs() === exp) pass_cnt++;
        else $display("FAIL %s: got on/busy/len/done/err/to=%b/%b/%0d/%b/%b/%b expected %b/%b/%0d/%b/%b/%b",
                      name, rx_data_on, rx_busy, rx_len, rx_done, rx_err_len, rx_timeout,
                      exp[15], exp[14], exp[13:3], exp[2], exp[1], exp[0]);
    endtask
    task automatic add(input logic a, ab, input logic [10:0] ml, input logic s, e, input logic [1:0] vr,
                       input logic don, bsy, input logic [10:0] ln, input logic dn, er);
        vecs.push_back('{a, ab, ml, s, e, vr, {don, bsy, ln, dn, er, 1'b0}});
    endtask
    task automatic drive(input logic a, ab, input logic [10:0] ml, input logic s, e, input logic [1:0] vr);
        rx_arm = a; rx_abort = ab; rx_max_len = ml; rx_sop_en = s; rx_lt_eop_en = e;
        {rx_lt_valid, rx_lt_ready} = vr;
        @(posedge clk);
        #1;
    endtask
    initial begin
        // normal packet, limit 8, one stalled beat
        add(1,0,8,0,0,0, 1,1,0,0,0);
        add(0,0,0,1,0,0, 1,1,0,0,0);
        add(0,0,0,0,0,3, 1,1,1,0,0);
        add(0,0,0,0,0,3, 1,1,2,0,0);
        add(0,0,0,0,0,2, 1,1,2,0,0);
        add(0,0,0,0,0,3, 1,1,3,0,0);
        add(0,0,0,0,0,3, 1,1,4,0,0);
        add(0,0,0,0,0,3, 1,1,5,0,0);
        add(0,0,0,0,1,3, 0,1,6,1,0);
        add(0,0,0,0,0,0, 0,0,6,0,0);
        // over-length, limit 4
        add(1,0,4,0,0,0, 1,1,6,0,0);
        add(0,0,0,1,0,0, 1,1,0,0,0);
        add(0,0,0,0,0,3, 1,1,1,0,0);
        add(0,0,0,0,0,3, 1,1,2,0,0);
        add(0,0,0,0,0,3, 1,1,3,0,0);
        add(0,0,0,0,0,3, 1,1,4,0,0);
        add(0,0,0,0,0,3, 0,0,5,0,1);
        add(0,0,0,0,0,0, 0,0,5,0,0);
        // EOP exactly at limit 4
        add(1,0,4,0,0,0, 1,1,5,0,0);
        add(0,0,0,1,0,0, 1,1,0,0,0);
        add(0,0,0,0,0,3, 1,1,1,0,0);
        add(0,0,0,0,0,3, 1,1,2,0,0);
        add(0,0,0,0,0,3, 1,1,3,0,0);
        add(0,0,0,0,1,3, 0,1,4,1,0);
        add(0,0,0,0,0,0, 0,0,4,0,0);
        // limit 3, EOP on beat 4; re-arm in DATA must not relatch the limit
        add(1,0,3,0,0,0, 1,1,4,0,0);
        add(0,0,0,1,0,0, 1,1,0,0,0);
        add(1,0,15,0,0,3, 1,1,1,0,0);
        add(0,0,0,0,0,3, 1,1,2,0,0);
        add(0,0,0,0,0,3, 1,1,3,0,0);
        add(0,0,0,0,1,3, 0,0,4,0,1);
        add(0,0,0,0,0,0, 0,0,4,0,0);
        // abort in DATA after 2 beats, abort wins over a same-cycle beat
        add(1,0,8,0,0,0, 1,1,4,0,0);
        add(0,0,0,1,0,0, 1,1,0,0,0);
        add(0,0,0,0,0,3, 1,1,1,0,0);
        add(0,0,0,0,0,3, 1,1,2,0,0);
        add(0,1,0,0,1,3, 0,0,2,0,0);
        add(0,0,0,0,0,0, 0,0,2,0,0);
        // abort in ARMED, abort beats a same-cycle arm
        add(1,0,8,0,0,0, 1,1,2,0,0);
        add(0,1,0,1,0,0, 0,0,2,0,0);
        add(1,1,8,0,0,0, 0,0,2,0,0);
        repeat (2) @(posedge clk);
        #1 check("reset_state", 16'h0);
        rst = 1'b0;
        #1 check("after_release", 16'h0);
        foreach (vecs[i]) begin
            drive(vecs[i].arm, vecs[i].abort, vecs[i].ml, vecs[i].sop, vecs[i].eop, vecs[i].vr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        // asynchronous reset mid-packet, then arm on the first edge after release
        drive(1,0,8,0,0,0);
        drive(0,0,0,1,0,0);
        drive(0,0,0,0,0,3);
        drive(0,0,0,0,0,3);
        check("pre_reset", {1'b1, 1'b1, 11'd2, 3'b000});
        #2 rst = 1'b1;
        #1 check("async_reset", 16'h0);
        @(negedge clk) rst = 1'b0;
        drive(1,0,8,0,0,0);
        check("first_arm", {1'b1, 1'b1, 11'd0, 3'b000});
`ifdef RX_DATA_TIMEOUT_EN
        repeat (9) drive(0,0,0,0,0,0);
        check("no_timeout_yet", {1'b1, 1'b1, 11'd0, 3'b000});
        drive(0,0,0,0,0,0);
        check("timeout_pulse", {1'b0, 1'b0, 11'd0, 3'b001});
        drive(0,0,0,0,0,0);
        check("timeout_clear", 16'h0);
`else
        repeat (100) drive(0,0,0,0,0,0);
        check("wait_forever", {1'b1, 1'b1, 11'd0, 3'b000});
        drive(0,1,0,0,0,0);
        check("abort_wait", 16'h0);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
